// File: rtl/cpu_mem_bridge_pkg.sv
// Shared widths, depths and counter sizing for the CPU/memory bridge.
package cpu_mem_bridge_pkg;

   localparam int ADDR_W_DEF     = 32;
   localparam int DATA_W_DEF     = 32;
   localparam int INST_DEPTH_DEF = 2;
   localparam int LOAD_DEPTH_DEF = 2;

   // Bits needed to hold a count from 0 to n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cpu_mem_bridge_tracker.sv
// Outstanding-request tracker: counts owed responses and how many to drop.
module req_tracker
   import cpu_mem_bridge_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          accept,
   input  logic          resp,
   input  logic          skip,
   output logic [CW-1:0] cnt,
   output logic          full,
   output logic          pass
);

   logic [CW-1:0] disc;
   logic          take;

   // A response with nothing owed is a protocol error and is ignored.
   assign take = resp && (cnt != '0);
   assign full = (cnt == CW'(DEPTH));
   assign pass = take && (disc == '0) && !skip;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         disc <= '0;
      end else begin
         cnt <= cnt + CW'(accept) - CW'(take);
         if (skip)
            disc <= cnt - CW'(take);
         else if (take && (disc != '0))
            disc <= disc - CW'(1);
      end
   end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridge from IF/MA/WB stages to sram-like inst/data ports.
module cpu_mem_bridge
   import cpu_mem_bridge_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int INST_DEPTH = INST_DEPTH_DEF,
   parameter int LOAD_DEPTH = LOAD_DEPTH_DEF,
   localparam int IW = cnt_w(INST_DEPTH),
   localparam int LW = cnt_w(LOAD_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              IF_enable,
   input  logic              IF_skip,
   input  logic [ADDR_W-1:0] IF_mem_addr,
   output logic              interlayer_IF_ready,
   output logic [DATA_W-1:0] IF_mem_rdata,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_rdata,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic              MA_mem_read,
   input  logic              MA_mem_write,
   input  logic [DATA_W/8-1:0] MA_mem_wstrb,
   input  logic [ADDR_W-1:0] MA_mem_addr,
   input  logic [2:0]        MA_mem_size,
   input  logic [DATA_W-1:0] MA_mem_wdata,
   output logic              interlayer_MA_ready,
   input  logic              WB_skip,
   output logic              interlayer_WB_ready,
   output logic [DATA_W-1:0] WB_mem_rdata,
   output logic              data_req,
   output logic              data_wr,
   output logic [ADDR_W-1:0] data_addr,
   output logic [2:0]        data_size,
   output logic [DATA_W/8-1:0] data_wstrb,
   output logic [DATA_W-1:0] data_wdata,
   input  logic [DATA_W-1:0] data_rdata,
   input  logic              data_read_ok,
   input  logic              data_write_full,
   output logic [IW-1:0]     inst_inflight,
   output logic [LW-1:0]     load_inflight
);

   logic inst_full, inst_pass, inst_acc;
   logic load_full, load_pass, load_acc;

   assign inst_req  = rst_n && IF_enable && !IF_skip && !inst_full;
   assign inst_addr = IF_mem_addr;
   assign inst_acc  = inst_req && inst_addr_ok;

   assign interlayer_IF_ready = rst_n && inst_pass;
   assign IF_mem_rdata        = inst_rdata;

   assign data_req = rst_n && ((MA_mem_read && !load_full) || MA_mem_write);
   assign interlayer_MA_ready =
      rst_n && !data_write_full && !(MA_mem_read && load_full);
   assign load_acc = MA_mem_read && interlayer_MA_ready;

   assign data_wr    = MA_mem_write;
   assign data_addr  = MA_mem_addr;
   assign data_size  = MA_mem_size;
   assign data_wstrb = MA_mem_wstrb;
   assign data_wdata = MA_mem_wdata;

   assign interlayer_WB_ready = rst_n && load_pass;
   assign WB_mem_rdata        = data_rdata;

   req_tracker #(.DEPTH(INST_DEPTH)) u_fetch (
      .clk    (clk),
      .rst_n  (rst_n),
      .accept (inst_acc),
      .resp   (inst_data_ok),
      .skip   (IF_skip),
      .cnt    (inst_inflight),
      .full   (inst_full),
      .pass   (inst_pass)
   );

   req_tracker #(.DEPTH(LOAD_DEPTH)) u_load (
      .clk    (clk),
      .rst_n  (rst_n),
      .accept (load_acc),
      .resp   (data_read_ok),
      .skip   (WB_skip),
      .cnt    (load_inflight),
      .full   (load_full),
      .pass   (load_pass)
   );

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Randomized and directed check of cpu_mem_bridge against a queue model.
module tb_cpu_mem_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int ID = 2;
   localparam int LD = 2;
   localparam int IW = $clog2(ID + 1);
   localparam int LW = $clog2(LD + 1);

   logic clk = 1'b0;
   logic rst_n;
   logic IF_enable, IF_skip;
   logic [AW-1:0] IF_mem_addr;
   logic interlayer_IF_ready;
   logic [DW-1:0] IF_mem_rdata;
   logic inst_req;
   logic [AW-1:0] inst_addr;
   logic [DW-1:0] inst_rdata;
   logic inst_addr_ok, inst_data_ok;
   logic MA_mem_read, MA_mem_write;
   logic [DW/8-1:0] MA_mem_wstrb;
   logic [AW-1:0] MA_mem_addr;
   logic [2:0] MA_mem_size;
   logic [DW-1:0] MA_mem_wdata;
   logic interlayer_MA_ready;
   logic WB_skip;
   logic interlayer_WB_ready;
   logic [DW-1:0] WB_mem_rdata;
   logic data_req, data_wr;
   logic [AW-1:0] data_addr;
   logic [2:0] data_size;
   logic [DW/8-1:0] data_wstrb;
   logic [DW-1:0] data_wdata;
   logic [DW-1:0] data_rdata;
   logic data_read_ok, data_write_full;
   logic [IW-1:0] inst_inflight;
   logic [LW-1:0] load_inflight;

   int n_chk = 0;
   int n_fail = 0;
   int err_cnt = 0;
   bit mvalid = 1'b0;
   // Each owed response: 1 = will be dropped, 0 = goes to the stage.
   bit iq[$];
   bit lq[$];

   always #5 clk = ~clk;

   cpu_mem_bridge dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .IF_enable           (IF_enable),
      .IF_skip             (IF_skip),
      .IF_mem_addr         (IF_mem_addr),
      .interlayer_IF_ready (interlayer_IF_ready),
      .IF_mem_rdata        (IF_mem_rdata),
      .inst_req            (inst_req),
      .inst_addr           (inst_addr),
      .inst_rdata          (inst_rdata),
      .inst_addr_ok        (inst_addr_ok),
      .inst_data_ok        (inst_data_ok),
      .MA_mem_read         (MA_mem_read),
      .MA_mem_write        (MA_mem_write),
      .MA_mem_wstrb        (MA_mem_wstrb),
      .MA_mem_addr         (MA_mem_addr),
      .MA_mem_size         (MA_mem_size),
      .MA_mem_wdata        (MA_mem_wdata),
      .interlayer_MA_ready (interlayer_MA_ready),
      .WB_skip             (WB_skip),
      .interlayer_WB_ready (interlayer_WB_ready),
      .WB_mem_rdata        (WB_mem_rdata),
      .data_req            (data_req),
      .data_wr             (data_wr),
      .data_addr           (data_addr),
      .data_size           (data_size),
      .data_wstrb          (data_wstrb),
      .data_wdata          (data_wdata),
      .data_rdata          (data_rdata),
      .data_read_ok        (data_read_ok),
      .data_write_full     (data_write_full),
      .inst_inflight       (inst_inflight),
      .load_inflight       (load_inflight)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit e_ireq();
      return rst_n && IF_enable && !IF_skip && (iq.size() < ID);
   endfunction
   function automatic bit e_ifrdy();
      return rst_n && inst_data_ok && (iq.size() > 0) && !iq[0] && !IF_skip;
   endfunction
   function automatic bit e_dreq();
      return rst_n && ((MA_mem_read && (lq.size() < LD)) || MA_mem_write);
   endfunction
   function automatic bit e_mardy();
      return rst_n && !data_write_full && !(MA_mem_read && (lq.size() == LD));
   endfunction
   function automatic bit e_wbrdy();
      return rst_n && data_read_ok && (lq.size() > 0) && !lq[0] && !WB_skip;
   endfunction

   // Reference model: queues of owed responses, advanced on each edge.
   always @(posedge clk) begin
      bit iacc, lacc;
      if (!rst_n) begin
         iq.delete();
         lq.delete();
         mvalid = 1'b1;
      end else if (mvalid) begin
         iacc = e_ireq() && inst_addr_ok;
         lacc = MA_mem_read && e_mardy();
         if (inst_data_ok) begin
            if (iq.size() > 0) void'(iq.pop_front());
            else err_cnt++;
         end
         if (IF_skip) foreach (iq[i]) iq[i] = 1'b1;
         if (iacc) iq.push_back(1'b0);
         if (data_read_ok) begin
            if (lq.size() > 0) void'(lq.pop_front());
            else err_cnt++;
         end
         if (WB_skip) foreach (lq[i]) lq[i] = 1'b1;
         if (lacc) lq.push_back(1'b0);
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("inst_req", 32'(inst_req), 32'(e_ireq()));
         chk("IF_ready", 32'(interlayer_IF_ready), 32'(e_ifrdy()));
         chk("data_req", 32'(data_req), 32'(e_dreq()));
         chk("MA_ready", 32'(interlayer_MA_ready), 32'(e_mardy()));
         chk("WB_ready", 32'(interlayer_WB_ready), 32'(e_wbrdy()));
         chk("inst_inflight", 32'(inst_inflight), iq.size());
         chk("load_inflight", 32'(load_inflight), lq.size());
         chk("inst_addr", inst_addr, IF_mem_addr);
         chk("IF_rdata", IF_mem_rdata, inst_rdata);
         chk("WB_rdata", WB_mem_rdata, data_rdata);
         chk("data_wr", 32'(data_wr), 32'(MA_mem_write));
         chk("data_addr", data_addr, MA_mem_addr);
         chk("data_wdata", data_wdata, MA_mem_wdata);
         chk("data_misc", {25'd0, data_size, data_wstrb},
             {25'd0, MA_mem_size, MA_mem_wstrb});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      IF_enable = 0; IF_skip = 0; IF_mem_addr = 32'h1000;
      inst_rdata = 0; inst_addr_ok = 0; inst_data_ok = 0;
      MA_mem_read = 0; MA_mem_write = 0; MA_mem_wstrb = 4'hF;
      MA_mem_addr = 32'h2000; MA_mem_size = 3'd2; MA_mem_wdata = 0;
      WB_skip = 0; data_rdata = 0; data_read_ok = 0; data_write_full = 0;
      tick();
      tick();
      rst_n = 1'b1;

      // Pipelined fetch up to the depth limit
      IF_enable = 1; inst_addr_ok = 1;
      #1 chk("c1_req", 32'(inst_req), 1);
      tick();
      #1 chk("c2_infl", 32'(inst_inflight), 1);
      tick();
      #1 chk("c3_req", 32'(inst_req), 0);
      chk("c3_infl", 32'(inst_inflight), 2);
      tick();
      inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h11112222;
      #1 chk("c4_rdy", 32'(interlayer_IF_ready), 1);
      tick();
      inst_data_ok = 0; inst_addr_ok = 1;
      #1 chk("c5_req", 32'(inst_req), 1);
      tick();
      // Redirect with two fetches owed
      inst_addr_ok = 0; IF_skip = 1;
      #1 chk("c6_req", 32'(inst_req), 0);
      tick();
      IF_skip = 0; inst_data_ok = 1;
      #1 chk("c7_rdy", 32'(interlayer_IF_ready), 0);
      tick();
      inst_addr_ok = 1;
      #1 chk("c8_rdy", 32'(interlayer_IF_ready), 0);
      tick();
      inst_addr_ok = 0; inst_rdata = 32'h24020001;
      #1 chk("c9_rdy", 32'(interlayer_IF_ready), 1);
      chk("c9_data", IF_mem_rdata, 32'h24020001);
      tick();
      // Skip coincident with a response, two owed
      inst_data_ok = 0; inst_addr_ok = 1;
      tick();
      tick();
      inst_addr_ok = 0; IF_skip = 1; inst_data_ok = 1;
      #1 chk("c12_rdy", 32'(interlayer_IF_ready), 0);
      tick();
      IF_skip = 0; inst_addr_ok = 1;
      #1 chk("c13_infl", 32'(inst_inflight), 1);
      chk("c13_rdy", 32'(interlayer_IF_ready), 0);
      tick();
      inst_addr_ok = 0;
      #1 chk("c14_rdy", 32'(interlayer_IF_ready), 1);
      tick();
      inst_data_ok = 0; IF_enable = 0;

      // Loads to the depth limit, store while full
      MA_mem_read = 1;
      #1 chk("l1_rdy", 32'(interlayer_MA_ready), 1);
      tick();
      #1 chk("l2_rdy", 32'(interlayer_MA_ready), 1);
      tick();
      #1 chk("l3_rdy", 32'(interlayer_MA_ready), 0);
      chk("l3_req", 32'(data_req), 0);
      chk("l3_infl", 32'(load_inflight), 2);
      tick();
      MA_mem_read = 0; MA_mem_write = 1;
      #1 chk("st_rdy", 32'(interlayer_MA_ready), 1);
      chk("st_req", 32'(data_req), 1);
      tick();
      MA_mem_write = 0; MA_mem_read = 1; data_read_ok = 1;
      #1 chk("l4_rdy", 32'(interlayer_MA_ready), 0);
      chk("l4_wb", 32'(interlayer_WB_ready), 1);
      tick();
      data_read_ok = 0;
      #1 chk("l5_rdy", 32'(interlayer_MA_ready), 1);
      tick();
      MA_mem_read = 0; data_read_ok = 1;
      tick();
      WB_skip = 1; data_rdata = 32'hDEADBEEF;
      #1 chk("wbs_rdy", 32'(interlayer_WB_ready), 0);
      chk("wbs_data", WB_mem_rdata, 32'hDEADBEEF);
      tick();
      WB_skip = 0; data_read_ok = 0;
      #1 chk("wbs_infl", 32'(load_inflight), 0);
      data_write_full = 1; MA_mem_read = 1;
      #1 chk("wf_rd", 32'(interlayer_MA_ready), 0);
      MA_mem_read = 0; MA_mem_write = 1;
      #1 chk("wf_wr", 32'(interlayer_MA_ready), 0);
      tick();
      data_write_full = 0; MA_mem_write = 0;

      // Reset with responses owed, then a stale response
      IF_enable = 1; inst_addr_ok = 1;
      tick();
      tick();
      IF_enable = 0; inst_addr_ok = 0; MA_mem_read = 1;
      tick();
      rst_n = 0; IF_enable = 1; inst_addr_ok = 1;
      #1 chk("rst_ireq", 32'(inst_req), 0);
      chk("rst_dreq", 32'(data_req), 0);
      chk("rst_ma", 32'(interlayer_MA_ready), 0);
      tick();
      rst_n = 1; IF_enable = 0; inst_addr_ok = 0; MA_mem_read = 0;
      #1 chk("rst_iinfl", 32'(inst_inflight), 0);
      chk("rst_linfl", 32'(load_inflight), 0);
      inst_data_ok = 1;
      #1 chk("stale_rdy", 32'(interlayer_IF_ready), 0);
      tick();
      inst_data_ok = 0;
      chk("proto_err", err_cnt, 1);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         int op;
         rst_n = ($urandom_range(0, 299) != 0);
         IF_enable = ($urandom_range(0, 3) != 0);
         IF_skip = ($urandom_range(0, 15) == 0);
         IF_mem_addr = $urandom;
         inst_addr_ok = ($urandom_range(0, 1) == 1);
         inst_data_ok = (iq.size() > 0) && ($urandom_range(0, 2) != 0);
         inst_rdata = $urandom;
         op = $urandom_range(0, 3);
         MA_mem_read = (op == 1) || (op == 3);
         MA_mem_write = (op == 2);
         MA_mem_wstrb = 4'($urandom);
         MA_mem_addr = $urandom;
         MA_mem_size = 3'($urandom);
         MA_mem_wdata = $urandom;
         WB_skip = ($urandom_range(0, 15) == 0);
         data_write_full = ($urandom_range(0, 7) == 0);
         data_read_ok = (lq.size() > 0) && ($urandom_range(0, 2) != 0);
         data_rdata = $urandom;
         tick();
      end
      rst_n = 1; inst_data_ok = 0; data_read_ok = 0;
      tick();
      chk("proto_err_end", err_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
